// File: rtl/usb_fs_nb_out_pe.sv
// usb_fs_nb_out_pe -- USB full-speed non-buffered OUT/SETUP protocol engine.
//
// Decodes OUT/SETUP tokens addressed to this device and streams the payload
// bytes of the DATA0/DATA1 packet that follows into the selected endpoint
// buffer. It then answers with ACK, NAK or STALL, or with no handshake for
// isochronous endpoints. The block holds no packet storage: the endpoint
// buffer is told to commit (acked) or to discard (rollback) each packet.
//
// Optional build macro:
//   USB_OUT_PE_TIMEOUT_EN - when this macro is defined, the engine abandons a
//                           token if no data packet starts within 96 cycles.
//
// Ports:
//   clk_48mhz_i, rst_i, link_reset_i - clock and synchronous resets
//   dev_addr_i                       - this device's USB address
//   out_ep_*_o                       - endpoint-side write/commit interface
//   out_ep_full/stall/iso_i          - per-endpoint status
//   data_toggle_clear_i              - per-endpoint toggle reset (expect DATA0)
//   rx_*_i                           - decoded receive packet stream
//   tx_pkt_start_o, tx_pid_o         - handshake request to the transmitter
//   tx_pkt_end_i                     - transmitter done (not needed here)

module usb_fs_nb_out_pe #(
  parameter int NumOutEps         = 12,
  parameter int MaxOutPktSizeByte = 32,
  parameter int PktW              = $clog2(MaxOutPktSizeByte),
  parameter int OutEpW            = $clog2(NumOutEps)
) (
  input  logic                 clk_48mhz_i,
  input  logic                 rst_i,
  input  logic                 link_reset_i,
  input  logic [6:0]           dev_addr_i,

  output logic [3:0]           out_ep_current_o,
  output logic                 out_ep_newpkt_o,
  output logic                 out_ep_setup_o,
  output logic [PktW-1:0]      out_ep_put_addr_o,
  output logic [7:0]           out_ep_data_o,
  output logic                 out_ep_data_put_o,
  output logic                 out_ep_acked_o,
  output logic                 out_ep_rollback_o,
  input  logic [NumOutEps-1:0] out_ep_full_i,
  input  logic [NumOutEps-1:0] out_ep_stall_i,
  input  logic [NumOutEps-1:0] out_ep_iso_i,
  input  logic [NumOutEps-1:0] data_toggle_clear_i,

  input  logic                 rx_pkt_start_i,
  input  logic                 rx_pkt_end_i,
  input  logic                 rx_pkt_valid_i,
  input  logic [3:0]           rx_pid_i,
  input  logic [6:0]           rx_addr_i,
  input  logic [3:0]           rx_endp_i,
  input  logic                 rx_data_put_i,
  input  logic [7:0]           rx_data_i,

  output logic                 tx_pkt_start_o,
  input  logic                 tx_pkt_end_i,
  output logic [3:0]           tx_pid_o
);

  localparam logic [3:0] PidOut   = 4'h1;
  localparam logic [3:0] PidSetup = 4'hD;
  localparam logic [3:0] PidData0 = 4'h3;
  localparam logic [3:0] PidData1 = 4'hB;
  localparam logic [3:0] PidAck   = 4'h2;
  localparam logic [3:0] PidNak   = 4'hA;
  localparam logic [3:0] PidStall = 4'hE;

  localparam logic [4:0] NumEpsW  = 5'(NumOutEps);

  typedef enum logic [1:0] {
    StIdle,
    StRcvdOut,
    StRcvdData,
    StSendHs
  } state_e;

  logic srst;
  assign srst = rst_i | link_reset_i;

  // The handshake is never waited on, so the transmitter's done strobe is
  // intentionally left unconnected.
  logic unused_tx_pkt_end;
  assign unused_tx_pkt_end = tx_pkt_end_i;

  state_e                state_q, state_d;
  logic [3:0]            current_q, current_d;
  logic                  setup_q, setup_d;
  logic                  newpkt_q, newpkt_d;
  logic [PktW-1:0]       put_addr_q, put_addr_d;
  logic [7:0]            data_q, data_d;
  logic                  data_put_q, data_put_d;
  logic                  last_written_q, last_written_d;
  logic                  overflow_q, overflow_d;
  logic                  toggle_bit_q, toggle_bit_d;
  logic [NumOutEps-1:0]  data_toggle_q, data_toggle_d;
  logic                  acked_q, acked_d;
  logic                  rollback_q, rollback_d;
`ifdef USB_OUT_PE_TIMEOUT_EN
  logic [6:0]            timeout_q, timeout_d;
`endif

  logic                  hs_start;
  logic [3:0]            hs_pid;
  logic                  accept_tok;

  logic                  tok_pid_ok;
  logic                  token_ok;
  logic                  tok_is_setup;
  logic [OutEpW-1:0]     tok_ep;
  logic [OutEpW-1:0]     ep_idx;
  logic                  data_pid_ok;

  assign tok_is_setup = (rx_pid_i == PidSetup);
  assign tok_pid_ok   = (rx_pid_i == PidOut) || tok_is_setup;
  assign token_ok     = rx_pkt_end_i & rx_pkt_valid_i & tok_pid_ok &
                        (rx_addr_i == dev_addr_i) &
                        ({1'b0, rx_endp_i} < NumEpsW);
  assign tok_ep       = rx_endp_i[OutEpW-1:0];
  assign ep_idx       = current_q[OutEpW-1:0];
  assign data_pid_ok  = (rx_pid_i == PidData0) || (rx_pid_i == PidData1);

  always_comb begin
    state_d        = state_q;
    current_d      = current_q;
    setup_d        = setup_q;
    newpkt_d       = 1'b0;
    put_addr_d     = put_addr_q;
    data_d         = data_q;
    data_put_d     = 1'b0;
    last_written_d = last_written_q;
    overflow_d     = overflow_q;
    toggle_bit_d   = toggle_bit_q;
    data_toggle_d  = data_toggle_q;
    acked_d        = 1'b0;
    rollback_d     = 1'b0;
    hs_start       = 1'b0;
    hs_pid         = 4'h0;
    accept_tok     = 1'b0;
`ifdef USB_OUT_PE_TIMEOUT_EN
    timeout_d      = 7'd0;
`endif

    // The offset advances only after the byte has been presented at it. The
    // last slot never wraps; instead we remember it is occupied so that the
    // next byte can be recognised as an overflow.
    if (data_put_q) begin
      if (put_addr_q != '1) begin
        put_addr_d = put_addr_q + 1'b1;
      end else begin
        last_written_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (token_ok) begin
          accept_tok = 1'b1;
          state_d    = StRcvdOut;
        end
      end

      StRcvdOut: begin
`ifdef USB_OUT_PE_TIMEOUT_EN
        timeout_d = timeout_q + 7'd1;
`endif
        if (token_ok) begin
          accept_tok = 1'b1;
`ifdef USB_OUT_PE_TIMEOUT_EN
          timeout_d  = 7'd0;
`endif
        end else if (rx_pkt_start_i) begin
          state_d = StRcvdData;
        end else if (rx_pkt_end_i) begin
          state_d = StIdle;
`ifdef USB_OUT_PE_TIMEOUT_EN
        end else if (timeout_q == 7'd95) begin
          state_d    = StIdle;
          rollback_d = 1'b1;
`endif
        end
      end

      StRcvdData: begin
        if (rx_data_put_i && !out_ep_full_i[ep_idx] && !overflow_q) begin
          // A byte still in flight to the last slot counts as written.
          if ((put_addr_q == '1) && (last_written_q || data_put_q)) begin
            overflow_d = 1'b1;
          end else begin
            data_d     = rx_data_i;
            data_put_d = 1'b1;
          end
        end
        if (rx_pkt_end_i) begin
          if (!rx_pkt_valid_i || !data_pid_ok) begin
            state_d    = StIdle;
            rollback_d = 1'b1;
          end else begin
            toggle_bit_d = rx_pid_i[3];
            state_d      = StSendHs;
          end
        end
      end

      StSendHs: begin
        state_d = StIdle;
        if (out_ep_stall_i[ep_idx] && !setup_q) begin
          hs_start   = 1'b1;
          hs_pid     = PidStall;
          rollback_d = 1'b1;
        end else if (out_ep_iso_i[ep_idx]) begin
          if (!out_ep_full_i[ep_idx] && !overflow_q) begin
            acked_d = 1'b1;
          end else begin
            rollback_d = 1'b1;
          end
        end else if (out_ep_full_i[ep_idx] || overflow_q) begin
          hs_start   = 1'b1;
          hs_pid     = PidNak;
          rollback_d = 1'b1;
        end else if (toggle_bit_q != data_toggle_q[ep_idx]) begin
          // Host retried a packet we already committed: ACK it again but
          // throw the copy away.
          hs_start   = 1'b1;
          hs_pid     = PidAck;
          rollback_d = 1'b1;
        end else begin
          hs_start              = 1'b1;
          hs_pid                = PidAck;
          acked_d               = 1'b1;
          data_toggle_d[ep_idx] = ~data_toggle_q[ep_idx];
        end
      end

      default: state_d = StIdle;
    endcase

    if (accept_tok) begin
      current_d      = rx_endp_i;
      setup_d        = tok_is_setup;
      newpkt_d       = 1'b1;
      put_addr_d     = '0;
      last_written_d = 1'b0;
      overflow_d     = 1'b0;
      if (tok_is_setup) begin
        data_toggle_d[tok_ep] = 1'b0;
      end
    end

    // An external clear overrides any toggle update made in the same cycle.
    data_toggle_d = data_toggle_d & ~data_toggle_clear_i;
  end

  always_ff @(posedge clk_48mhz_i) begin
    if (srst) begin
      state_q        <= StIdle;
      current_q      <= '0;
      setup_q        <= 1'b0;
      newpkt_q       <= 1'b0;
      put_addr_q     <= '0;
      data_q         <= '0;
      data_put_q     <= 1'b0;
      last_written_q <= 1'b0;
      overflow_q     <= 1'b0;
      toggle_bit_q   <= 1'b0;
      data_toggle_q  <= '0;
      acked_q        <= 1'b0;
      rollback_q     <= 1'b0;
`ifdef USB_OUT_PE_TIMEOUT_EN
      timeout_q      <= 7'd0;
`endif
    end else begin
      state_q        <= state_d;
      current_q      <= current_d;
      setup_q        <= setup_d;
      newpkt_q       <= newpkt_d;
      put_addr_q     <= put_addr_d;
      data_q         <= data_d;
      data_put_q     <= data_put_d;
      last_written_q <= last_written_d;
      overflow_q     <= overflow_d;
      toggle_bit_q   <= toggle_bit_d;
      data_toggle_q  <= data_toggle_d;
      acked_q        <= acked_d;
      rollback_q     <= rollback_d;
`ifdef USB_OUT_PE_TIMEOUT_EN
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign out_ep_current_o  = current_q;
  assign out_ep_newpkt_o   = newpkt_q;
  assign out_ep_setup_o    = setup_q;
  assign out_ep_put_addr_o = put_addr_q;
  assign out_ep_data_o     = data_q;
  assign out_ep_data_put_o = data_put_q;
  assign out_ep_acked_o    = acked_q;
  assign out_ep_rollback_o = rollback_q;
  assign tx_pkt_start_o    = hs_start;
  assign tx_pid_o          = hs_pid;

endmodule

// File: tb/tb_usb_fs_nb_out_pe.sv
module tb_usb_fs_nb_out_pe;

  localparam int NumOutEps = 12;
  localparam int PktW      = 5;
  localparam logic [6:0] Dev = 7'h05;
  localparam logic [3:0] POut = 4'h1, PSetup = 4'hD, PD0 = 4'h3, PD1 = 4'hB;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic                 rst_i, link_reset_i;
  logic [6:0]           dev_addr_i;
  logic [3:0]           out_ep_current_o;
  logic                 out_ep_newpkt_o, out_ep_setup_o;
  logic [PktW-1:0]      out_ep_put_addr_o;
  logic [7:0]           out_ep_data_o;
  logic                 out_ep_data_put_o, out_ep_acked_o, out_ep_rollback_o;
  logic [NumOutEps-1:0] out_ep_full_i, out_ep_stall_i, out_ep_iso_i, data_toggle_clear_i;
  logic                 rx_pkt_start_i, rx_pkt_end_i, rx_pkt_valid_i;
  logic [3:0]           rx_pid_i;
  logic [6:0]           rx_addr_i;
  logic [3:0]           rx_endp_i;
  logic                 rx_data_put_i;
  logic [7:0]           rx_data_i;
  logic                 tx_pkt_start_o, tx_pkt_end_i;
  logic [3:0]           tx_pid_o;

  usb_fs_nb_out_pe dut (
    .clk_48mhz_i        (clk),
    .rst_i              (rst_i),
    .link_reset_i       (link_reset_i),
    .dev_addr_i         (dev_addr_i),
    .out_ep_current_o   (out_ep_current_o),
    .out_ep_newpkt_o    (out_ep_newpkt_o),
    .out_ep_setup_o     (out_ep_setup_o),
    .out_ep_put_addr_o  (out_ep_put_addr_o),
    .out_ep_data_o      (out_ep_data_o),
    .out_ep_data_put_o  (out_ep_data_put_o),
    .out_ep_acked_o     (out_ep_acked_o),
    .out_ep_rollback_o  (out_ep_rollback_o),
    .out_ep_full_i      (out_ep_full_i),
    .out_ep_stall_i     (out_ep_stall_i),
    .out_ep_iso_i       (out_ep_iso_i),
    .data_toggle_clear_i(data_toggle_clear_i),
    .rx_pkt_start_i     (rx_pkt_start_i),
    .rx_pkt_end_i       (rx_pkt_end_i),
    .rx_pkt_valid_i     (rx_pkt_valid_i),
    .rx_pid_i           (rx_pid_i),
    .rx_addr_i          (rx_addr_i),
    .rx_endp_i          (rx_endp_i),
    .rx_data_put_i      (rx_data_put_i),
    .rx_data_i          (rx_data_i),
    .tx_pkt_start_o     (tx_pkt_start_o),
    .tx_pkt_end_i       (tx_pkt_end_i),
    .tx_pid_o           (tx_pid_o)
  );

  // Output monitor: counts strobes and logs every byte write.
  int       put_cnt = 0, tx_cnt = 0, ack_cnt = 0, rb_cnt = 0, np_cnt = 0;
  logic [3:0] last_tx_pid = 4'h0;
  logic [7:0] put_data_log [0:1023];
  logic [PktW-1:0] put_addr_log [0:1023];

  always @(negedge clk) begin
    if (out_ep_data_put_o) begin
      put_data_log[put_cnt & 1023] = out_ep_data_o;
      put_addr_log[put_cnt & 1023] = out_ep_put_addr_o;
      put_cnt++;
    end
    if (tx_pkt_start_o) begin
      last_tx_pid = tx_pid_o;
      tx_cnt++;
    end
    if (out_ep_acked_o)    ack_cnt++;
    if (out_ep_rollback_o) rb_cnt++;
    if (out_ep_newpkt_o)   np_cnt++;
  end

  int n_cmp = 0, n_bad = 0;
  int s_put, s_tx, s_ack, s_rb, s_np;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_put = put_cnt; s_tx = tx_cnt; s_ack = ack_cnt; s_rb = rb_cnt; s_np = np_cnt;
  endtask

  task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
    rx_pkt_start_i = 1'b1;
    tick();
    rx_pkt_start_i = 1'b0;
    repeat (3) tick();
    rx_pid_i = pid; rx_addr_i = addr; rx_endp_i = ep;
    rx_pkt_end_i = 1'b1; rx_pkt_valid_i = 1'b1;
    tick();
    rx_pkt_end_i = 1'b0; rx_pkt_valid_i = 1'b0;
    repeat (2) tick();
    $display("token pid=%h addr=%h ep=%0d", pid, addr, ep);
  endtask

  task automatic send_data(input logic [3:0] pid, input int n, input logic [7:0] base, input logic valid);
    logic [7:0] b;
    rx_pid_i = pid;
    rx_pkt_start_i = 1'b1;
    tick();
    rx_pkt_start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (2) tick();
      b = base + 8'(i);
      rx_data_put_i = 1'b1; rx_data_i = b;
      tick();
      rx_data_put_i = 1'b0;
    end
    repeat (2) tick();
    rx_pkt_end_i = 1'b1; rx_pkt_valid_i = valid;
    tick();
    rx_pkt_end_i = 1'b0; rx_pkt_valid_i = 1'b0;
    repeat (5) tick();
    $display("data pid=%h bytes=%0d valid=%0b -> puts=%0d tx=%0d pid=%h acked=%0d rollback=%0d",
             pid, n, valid, put_cnt - s_put, tx_cnt - s_tx, last_tx_pid, ack_cnt - s_ack, rb_cnt - s_rb);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; link_reset_i = 1'b0; dev_addr_i = Dev;
    out_ep_full_i = '0; out_ep_stall_i = '0; out_ep_iso_i = '0; data_toggle_clear_i = '0;
    rx_pkt_start_i = 0; rx_pkt_end_i = 0; rx_pkt_valid_i = 0; rx_pid_i = 0;
    rx_addr_i = 0; rx_endp_i = 0; rx_data_put_i = 0; rx_data_i = 0; tx_pkt_end_i = 0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    n_cmp++; if ({out_ep_newpkt_o, out_ep_data_put_o, out_ep_acked_o, out_ep_rollback_o, tx_pkt_start_o} !== 5'b0) begin
      n_bad++; $display("FAIL reset_strobes got %b exp 00000", {out_ep_newpkt_o, out_ep_data_put_o, out_ep_acked_o, out_ep_rollback_o, tx_pkt_start_o});
    end
    n_cmp++; if ({out_ep_current_o, out_ep_setup_o, out_ep_put_addr_o, out_ep_data_o, tx_pid_o} !== 22'h0) begin
      n_bad++; $display("FAIL reset_values got %h exp 0", {out_ep_current_o, out_ep_setup_o, out_ep_put_addr_o, out_ep_data_o, tx_pid_o});
    end
  endtask

  task automatic test_addr_filter();
    snap();
    send_token(POut, 7'h06, 4'd2);
    send_token(POut, Dev, 4'd12);
    n_cmp++; if (np_cnt - s_np !== 0) begin
      n_bad++; $display("FAIL filter_newpkt got %0d exp 0", np_cnt - s_np);
    end
    send_data(PD0, 2, 8'h11, 1'b1);
    n_cmp++; if ((put_cnt - s_put) + (tx_cnt - s_tx) + (rb_cnt - s_rb) + (ack_cnt - s_ack) !== 0) begin
      n_bad++; $display("FAIL filter_ignored got %0d events exp 0", (put_cnt - s_put) + (tx_cnt - s_tx) + (rb_cnt - s_rb) + (ack_cnt - s_ack));
    end
  endtask

  task automatic test_out_ack();
    snap();
    send_token(POut, Dev, 4'd2);
    n_cmp++; if (np_cnt - s_np !== 1) begin n_bad++; $display("FAIL ack_newpkt got %0d exp 1", np_cnt - s_np); end
    n_cmp++; if (out_ep_current_o !== 4'd2) begin n_bad++; $display("FAIL ack_current got %0d exp 2", out_ep_current_o); end
    n_cmp++; if (out_ep_setup_o !== 1'b0) begin n_bad++; $display("FAIL ack_setup got %b exp 0", out_ep_setup_o); end
    send_data(PD0, 4, 8'hA1, 1'b1);
    n_cmp++; if (put_cnt - s_put !== 4) begin n_bad++; $display("FAIL ack_puts got %0d exp 4", put_cnt - s_put); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (put_data_log[(s_put + i) & 1023] !== 8'hA1 + 8'(i) || put_addr_log[(s_put + i) & 1023] !== 5'(i)) begin
        n_bad++; $display("FAIL ack_byte%0d got %h@%0d exp %h@%0d", i, put_data_log[(s_put + i) & 1023], put_addr_log[(s_put + i) & 1023], 8'hA1 + 8'(i), i);
      end
    end
    n_cmp++; if (tx_cnt - s_tx !== 1 || last_tx_pid !== 4'h2) begin n_bad++; $display("FAIL ack_hs got %0d/%h exp 1/2", tx_cnt - s_tx, last_tx_pid); end
    n_cmp++; if (ack_cnt - s_ack !== 1 || rb_cnt - s_rb !== 0) begin n_bad++; $display("FAIL ack_commit got %0d/%0d exp 1/0", ack_cnt - s_ack, rb_cnt - s_rb); end
  endtask

  task automatic test_duplicate();
    snap();
    send_token(POut, Dev, 4'd2);
    send_data(PD0, 4, 8'hA1, 1'b1);
    n_cmp++; if (tx_cnt - s_tx !== 1 || last_tx_pid !== 4'h2) begin n_bad++; $display("FAIL dup_hs got %0d/%h exp 1/2", tx_cnt - s_tx, last_tx_pid); end
    n_cmp++; if (ack_cnt - s_ack !== 0 || rb_cnt - s_rb !== 1) begin n_bad++; $display("FAIL dup_commit got %0d/%0d exp 0/1", ack_cnt - s_ack, rb_cnt - s_rb); end
  endtask

  task automatic test_nak_stall();
    out_ep_full_i[2] = 1'b1;
    snap();
    send_token(POut, Dev, 4'd2);
    send_data(PD1, 3, 8'h20, 1'b1);
    n_cmp++; if (put_cnt - s_put !== 0) begin n_bad++; $display("FAIL nak_puts got %0d exp 0", put_cnt - s_put); end
    n_cmp++; if (tx_cnt - s_tx !== 1 || last_tx_pid !== 4'hA) begin n_bad++; $display("FAIL nak_hs got %0d/%h exp 1/a", tx_cnt - s_tx, last_tx_pid); end
    n_cmp++; if (ack_cnt - s_ack !== 0 || rb_cnt - s_rb !== 1) begin n_bad++; $display("FAIL nak_commit got %0d/%0d exp 0/1", ack_cnt - s_ack, rb_cnt - s_rb); end
    out_ep_full_i[2] = 1'b0;
    out_ep_stall_i[2] = 1'b1;
    snap();
    send_token(POut, Dev, 4'd2);
    send_data(PD1, 3, 8'h20, 1'b1);
    n_cmp++; if (tx_cnt - s_tx !== 1 || last_tx_pid !== 4'hE) begin n_bad++; $display("FAIL stall_hs got %0d/%h exp 1/e", tx_cnt - s_tx, last_tx_pid); end
    n_cmp++; if (ack_cnt - s_ack !== 0 || rb_cnt - s_rb !== 1) begin n_bad++; $display("FAIL stall_commit got %0d/%0d exp 0/1", ack_cnt - s_ack, rb_cnt - s_rb); end
    out_ep_stall_i[2] = 1'b0;
    snap();
    send_token(POut, Dev, 4'd2);
    send_data(PD1, 2, 8'h30, 1'b1);
    n_cmp++; if (ack_cnt - s_ack !== 1 || last_tx_pid !== 4'h2) begin n_bad++; $display("FAIL data1_ack got %0d/%h exp 1/2", ack_cnt - s_ack, last_tx_pid); end
  endtask

  task automatic test_setup();
    out_ep_stall_i[0] = 1'b1;
    snap();
    send_token(PSetup, Dev, 4'd0);
    n_cmp++; if (out_ep_setup_o !== 1'b1 || out_ep_current_o !== 4'd0) begin n_bad++; $display("FAIL setup_flag got %b/%0d exp 1/0", out_ep_setup_o, out_ep_current_o); end
    send_data(PD0, 8, 8'h10, 1'b1);
    n_cmp++; if (put_cnt - s_put !== 8) begin n_bad++; $display("FAIL setup_puts got %0d exp 8", put_cnt - s_put); end
    n_cmp++; if (tx_cnt - s_tx !== 1 || last_tx_pid !== 4'h2) begin n_bad++; $display("FAIL setup_hs got %0d/%h exp 1/2", tx_cnt - s_tx, last_tx_pid); end
    n_cmp++; if (ack_cnt - s_ack !== 1 || rb_cnt - s_rb !== 0) begin n_bad++; $display("FAIL setup_commit got %0d/%0d exp 1/0", ack_cnt - s_ack, rb_cnt - s_rb); end
    out_ep_stall_i[0] = 1'b0;
    // toggle[0] is now 1; an external clear makes DATA0 acceptable again
    data_toggle_clear_i[0] = 1'b1;
    tick();
    data_toggle_clear_i[0] = 1'b0;
    snap();
    send_token(POut, Dev, 4'd0);
    n_cmp++; if (out_ep_setup_o !== 1'b0) begin n_bad++; $display("FAIL out_after_setup got %b exp 0", out_ep_setup_o); end
    send_data(PD0, 1, 8'h55, 1'b1);
    n_cmp++; if (ack_cnt - s_ack !== 1 || rb_cnt - s_rb !== 0) begin n_bad++; $display("FAIL clear_commit got %0d/%0d exp 1/0", ack_cnt - s_ack, rb_cnt - s_rb); end
  endtask

  task automatic test_overflow();
    snap();
    send_token(POut, Dev, 4'd1);
    send_data(PD0, 33, 8'h40, 1'b1);
    n_cmp++; if (put_cnt - s_put !== 32) begin n_bad++; $display("FAIL ovf_puts got %0d exp 32", put_cnt - s_put); end
    n_cmp++; if (put_data_log[(s_put + 31) & 1023] !== 8'h5F || put_addr_log[(s_put + 31) & 1023] !== 5'd31) begin
      n_bad++; $display("FAIL ovf_last got %h@%0d exp 5f@31", put_data_log[(s_put + 31) & 1023], put_addr_log[(s_put + 31) & 1023]);
    end
    n_cmp++; if (tx_cnt - s_tx !== 1 || last_tx_pid !== 4'hA) begin n_bad++; $display("FAIL ovf_hs got %0d/%h exp 1/a", tx_cnt - s_tx, last_tx_pid); end
    n_cmp++; if (ack_cnt - s_ack !== 0 || rb_cnt - s_rb !== 1) begin n_bad++; $display("FAIL ovf_commit got %0d/%0d exp 0/1", ack_cnt - s_ack, rb_cnt - s_rb); end
    snap();
    send_token(POut, Dev, 4'd1);
    send_data(PD0, 32, 8'h80, 1'b1);
    n_cmp++; if (put_cnt - s_put !== 32 || put_addr_log[s_put & 1023] !== 5'd0) begin n_bad++; $display("FAIL full32_puts got %0d first@%0d exp 32 first@0", put_cnt - s_put, put_addr_log[s_put & 1023]); end
    n_cmp++; if (last_tx_pid !== 4'h2 || ack_cnt - s_ack !== 1 || rb_cnt - s_rb !== 0) begin
      n_bad++; $display("FAIL full32_hs got %h/%0d/%0d exp 2/1/0", last_tx_pid, ack_cnt - s_ack, rb_cnt - s_rb);
    end
  endtask

  task automatic test_iso();
    out_ep_iso_i[3] = 1'b1;
    snap();
    send_token(POut, Dev, 4'd3);
    send_data(PD0, 4, 8'hC0, 1'b0);
    n_cmp++; if (tx_cnt - s_tx !== 0) begin n_bad++; $display("FAIL iso_bad_tx got %0d exp 0", tx_cnt - s_tx); end
    n_cmp++; if (ack_cnt - s_ack !== 0 || rb_cnt - s_rb !== 1) begin n_bad++; $display("FAIL iso_bad_commit got %0d/%0d exp 0/1", ack_cnt - s_ack, rb_cnt - s_rb); end
    snap();
    send_token(POut, Dev, 4'd3);
    send_data(PD0, 4, 8'hC0, 1'b1);
    n_cmp++; if (tx_cnt - s_tx !== 0) begin n_bad++; $display("FAIL iso_good_tx got %0d exp 0", tx_cnt - s_tx); end
    n_cmp++; if (ack_cnt - s_ack !== 1 || rb_cnt - s_rb !== 0) begin n_bad++; $display("FAIL iso_good_commit got %0d/%0d exp 1/0", ack_cnt - s_ack, rb_cnt - s_rb); end
    out_ep_iso_i[3] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addr_filter();
    test_out_ack();
    test_duplicate();
    test_nak_stall();
    test_setup();
    test_overflow();
    test_iso();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
